// File: rtl/multicycle_control.sv
//------------------------------------------------------------------------------
// Module   : multicycle_control
// Brief    : Control sequencer for a multi-cycle RV32I-subset core.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [6:0]       i_opcode,
    input  logic [2:0]       i_func3,
    input  logic             i_zero,
    input  logic             i_mem_ready,
    output logic [1:0]       o_ALUop,
    output logic             o_func7_mask,
    output logic [1:0]       o_alu_src_a,
    output logic [1:0]       o_alu_src_b,
    output logic             o_pc_write,
    output logic             o_pc_src,
    output logic             o_ir_write,
    output logic             o_reg_write,
    output logic [1:0]       o_wb_sel,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic             o_iord,
    output logic             o_trap,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_retired
);

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_IALU   = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_retired;
    logic               w_retire;

    logic [1:0] w_aluop;
    logic       w_func7_mask;
    logic [1:0] w_src_a;
    logic [1:0] w_src_b;
    logic       w_pc_write;
    logic       w_pc_src;
    logic       w_ir_write;
    logic       w_reg_write;
    logic [1:0] w_wb_sel;
    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_iord;
    logic       w_trap;
    logic       w_legal;
    logic       w_taken;

    always_comb begin
        w_legal = (i_opcode == c_OP_R)      || (i_opcode == c_OP_IALU)  ||
                  (i_opcode == c_OP_LOAD)   || (i_opcode == c_OP_STORE) ||
                  (i_opcode == c_OP_BRANCH) || (i_opcode == c_OP_JAL);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_retire     = 1'b0;
        w_aluop      = 2'b00;
        w_func7_mask = 1'b0;
        w_src_a      = 2'b00;
        w_src_b      = 2'b00;
        w_pc_write   = 1'b0;
        w_pc_src     = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_wb_sel     = 2'b00;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_iord       = 1'b0;
        w_trap       = 1'b0;
        w_taken      = 1'b0;

        case (r_state)
            ST_FETCH: begin
                w_mem_req = 1'b1;
                if (i_mem_ready) begin
                    // Instruction lands in IR while the ALU forms PC+4
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_src_b    = 2'b01;
                    w_next     = ST_DECODE;
                end
            end

            ST_DECODE: begin
                w_src_a = 2'b10;
                w_src_b = 2'b10;
                w_next  = w_legal ? ST_EXEC : ST_TRAP;
            end

            ST_EXEC: begin
                case (i_opcode)
                    c_OP_R: begin
                        w_src_a = 2'b01;
                        w_aluop = 2'b10;
                        w_next  = ST_WB;
                    end
                    c_OP_IALU: begin
                        // Only shifts carry a meaningful func7 bit in the immediate
                        w_src_a      = 2'b01;
                        w_src_b      = 2'b10;
                        w_aluop      = 2'b10;
                        w_func7_mask = (i_func3 != 3'b001) && (i_func3 != 3'b101);
                        w_next       = ST_WB;
                    end
                    c_OP_LOAD, c_OP_STORE: begin
                        w_src_a = 2'b01;
                        w_src_b = 2'b10;
                        w_next  = ST_MEM;
                    end
                    c_OP_BRANCH: begin
                        w_src_a = 2'b01;
                        w_aluop = 2'b01;
                        if (i_func3 == 3'b000 || i_func3 == 3'b001) begin
                            w_taken    = (i_func3 == 3'b000) ? i_zero : !i_zero;
                            w_pc_write = w_taken;
                            w_pc_src   = w_taken;
                            w_retire   = 1'b1;
                            w_next     = ST_FETCH;
                        end else begin
                            w_next = ST_TRAP;
                        end
                    end
                    c_OP_JAL: begin
                        w_reg_write = 1'b1;
                        w_wb_sel    = 2'b10;
                        w_pc_write  = 1'b1;
                        w_pc_src    = 1'b1;
                        w_retire    = 1'b1;
                        w_next      = ST_FETCH;
                    end
                    default: begin
                        w_next = ST_TRAP;
                    end
                endcase
            end

            ST_MEM: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                w_mem_we  = (i_opcode == c_OP_STORE);
                if (i_mem_ready) begin
                    if (i_opcode == c_OP_STORE) begin
                        w_retire = 1'b1;
                        w_next   = ST_FETCH;
                    end else begin
                        w_next = ST_WB;
                    end
                end
            end

            ST_WB: begin
                w_reg_write = 1'b1;
                w_wb_sel    = (i_opcode == c_OP_LOAD) ? 2'b01 : 2'b00;
                w_retire    = 1'b1;
                w_next      = ST_FETCH;
            end

            default: begin
                // TRAP and the unused codes 5/6 all park here until reset
                w_trap = 1'b1;
                w_next = ST_TRAP;
            end
        endcase
    end

    // Reset is synchronous, so gate outputs to keep the memory port quiet during it
    assign o_ALUop      = i_rst ? 2'b00 : w_aluop;
    assign o_func7_mask = i_rst ? 1'b0  : w_func7_mask;
    assign o_alu_src_a  = i_rst ? 2'b00 : w_src_a;
    assign o_alu_src_b  = i_rst ? 2'b00 : w_src_b;
    assign o_pc_write   = i_rst ? 1'b0  : w_pc_write;
    assign o_pc_src     = i_rst ? 1'b0  : w_pc_src;
    assign o_ir_write   = i_rst ? 1'b0  : w_ir_write;
    assign o_reg_write  = i_rst ? 1'b0  : w_reg_write;
    assign o_wb_sel     = i_rst ? 2'b00 : w_wb_sel;
    assign o_mem_req    = i_rst ? 1'b0  : w_mem_req;
    assign o_mem_we     = i_rst ? 1'b0  : w_mem_we;
    assign o_iord       = i_rst ? 1'b0  : w_iord;
    assign o_trap       = i_rst ? 1'b0  : w_trap;
    assign o_state      = i_rst ? 3'd0  : r_state;
    assign o_retired    = i_rst ? '0    : r_retired;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
//------------------------------------------------------------------------------
// Module   : tb_multicycle_control
// Brief    : Randomized self-checking bench for multicycle_control.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control;

    localparam int CNT_W = 4;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic             clk = 1'b0;
    logic             rst;
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic             zero;
    logic             mem_ready;
    logic [1:0]       aluop;
    logic             func7_mask;
    logic [1:0]       src_a;
    logic [1:0]       src_b;
    logic             pc_write;
    logic             pc_src;
    logic             ir_write;
    logic             reg_write;
    logic [1:0]       wb_sel;
    logic             mem_req;
    logic             mem_we;
    logic             iord;
    logic             trap;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    int n_chk  = 0;
    int n_pass = 0;
    int model_ret = 0;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_opcode     (opcode),
        .i_func3      (func3),
        .i_zero       (zero),
        .i_mem_ready  (mem_ready),
        .o_ALUop      (aluop),
        .o_func7_mask (func7_mask),
        .o_alu_src_a  (src_a),
        .o_alu_src_b  (src_b),
        .o_pc_write   (pc_write),
        .o_pc_src     (pc_src),
        .o_ir_write   (ir_write),
        .o_reg_write  (reg_write),
        .o_wb_sel     (wb_sel),
        .o_mem_req    (mem_req),
        .o_mem_we     (mem_we),
        .o_iord       (iord),
        .o_trap       (trap),
        .o_state      (state),
        .o_retired    (retired)
    );

    always #5 clk = ~clk;

    logic [21:0] obs;
    assign obs = {aluop, func7_mask, src_a, src_b, pc_write, pc_src, ir_write,
                  reg_write, wb_sel, mem_req, mem_we, iord, trap, state};

    function automatic logic [21:0] pk(
        input logic [1:0] op, input logic mk, input logic [1:0] sa, input logic [1:0] sb,
        input logic pw, input logic ps, input logic iw, input logic rw, input logic [1:0] wb,
        input logic mr, input logic mw, input logic io, input logic tr, input logic [2:0] st);
        return {op, mk, sa, sb, pw, ps, iw, rw, wb, mr, mw, io, tr, st};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // One clock: inputs already set, outputs compared mid-cycle
    task automatic cyc(input string tag, input logic [21:0] exp);
        @(negedge clk);
        chk(tag, 32'(obs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mem_ready = 1'($urandom);
            @(negedge clk);
            chk("rst_outputs", 32'(obs), 32'd0);
            chk("rst_retired", 32'(retired), 32'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        model_ret = 0;
    endtask

    task automatic trap_hold(input int n);
        for (int k = 0; k < n; k++) begin
            mem_ready = 1'($urandom);
            cyc("trap_sticky", pk(0,0,0,0,0,0,0,0,0,0,0,0,1,3'd7));
        end
    endtask

    // Steps one instruction through the DUT, expecting the spec's per-phase controls.
    // rst_at_mem >= 0 aborts the instruction with reset during that MEM wait cycle.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                             input int fw, input int mw, input int rst_at_mem,
                             output bit trapped);
        bit legal, is_mem, is_ld, is_st, retires_in_exec;
        logic tk, mk;
        trapped = 0;
        opcode = op; func3 = f3; zero = z;
        is_ld = (op == OP_LD);
        is_st = (op == OP_ST);
        is_mem = is_ld || is_st;
        legal = (op == OP_R) || (op == OP_I) || is_mem || (op == OP_BR) || (op == OP_JAL);

        for (int k = 0; k < fw; k++) begin
            mem_ready = 1'b0;
            cyc("fetch_wait", pk(0,0,0,0,0,0,0,0,0,1,0,0,0,3'd0));
        end
        mem_ready = 1'b1;
        cyc("fetch", pk(0,0,0,1,1,0,1,0,0,1,0,0,0,3'd0));

        mem_ready = 1'($urandom);
        cyc("decode", pk(0,0,2,2,0,0,0,0,0,0,0,0,0,3'd1));
        if (!legal) begin
            trapped = 1;
            return;
        end

        mem_ready = 1'($urandom);
        retires_in_exec = 0;
        if (op == OP_R) begin
            cyc("exec_r", pk(2,0,1,0,0,0,0,0,0,0,0,0,0,3'd2));
        end else if (op == OP_I) begin
            mk = (f3 != 3'b001) && (f3 != 3'b101);
            cyc("exec_i", pk(2,mk,1,2,0,0,0,0,0,0,0,0,0,3'd2));
        end else if (is_mem) begin
            cyc("exec_mem", pk(0,0,1,2,0,0,0,0,0,0,0,0,0,3'd2));
        end else if (op == OP_BR) begin
            if (f3 == 3'b000 || f3 == 3'b001) begin
                tk = (f3 == 3'b000) ? z : !z;
                cyc("exec_br", pk(1,0,1,0,tk,tk,0,0,0,0,0,0,0,3'd2));
                retires_in_exec = 1;
            end else begin
                cyc("exec_br_bad", pk(1,0,1,0,0,0,0,0,0,0,0,0,0,3'd2));
                trapped = 1;
                return;
            end
        end else begin
            cyc("exec_jal", pk(0,0,0,0,1,1,0,1,2,0,0,0,0,3'd2));
            retires_in_exec = 1;
        end

        if (is_mem) begin
            for (int k = 0; k <= mw; k++) begin
                if (k == rst_at_mem) begin
                    rst = 1'b1;
                    mem_ready = 1'b0;
                    @(negedge clk);
                    chk("rst_in_mem", 32'(obs), 32'd0);
                    @(posedge clk);
                    #1;
                    rst = 1'b0;
                    model_ret = 0;
                    return;
                end
                mem_ready = (k == mw);
                cyc("mem", pk(0,0,0,0,0,0,0,0,0,1,is_st,1,0,3'd3));
            end
        end

        if (!retires_in_exec && !is_st) begin
            mem_ready = 1'($urandom);
            cyc("wb", pk(0,0,0,0,0,0,0,1,is_ld ? 2'b01 : 2'b00,0,0,0,0,3'd4));
        end

        model_ret++;
        chk("retired", 32'(retired), 32'(model_ret % (1 << CNT_W)));
    endtask

    task automatic pick(input bit allow_bad, output logic [6:0] op, output logic [2:0] f3);
        int r;
        r = $urandom_range(0, 19);
        f3 = 3'($urandom);
        if      (r < 3)  op = OP_R;
        else if (r < 6)  op = OP_I;
        else if (r < 9)  op = OP_LD;
        else if (r < 12) op = OP_ST;
        else if (r < 16) op = OP_BR;
        else if (r < 18) op = OP_JAL;
        else if (r == 18 && allow_bad) op = OP_BAD;
        else op = OP_R;
        if (op == OP_BR && !(allow_bad && $urandom_range(0, 5) == 0)) f3 = {2'b00, f3[0]};
    endtask

    initial begin
        bit tr;
        logic [6:0] op;
        logic [2:0] f3;
        rst = 1'b1; opcode = OP_R; func3 = 3'd0; zero = 1'b0; mem_ready = 1'b0;
        #1;
        do_reset();

        // Directed: the basic instruction classes
        run_instr(OP_R,  3'b000, 1'b0, 0, 0, -1, tr);
        run_instr(OP_I,  3'b000, 1'b0, 0, 0, -1, tr);
        run_instr(OP_I,  3'b101, 1'b0, 0, 0, -1, tr);
        run_instr(OP_LD, 3'b010, 1'b0, 0, 3, -1, tr);
        run_instr(OP_BR, 3'b000, 1'b1, 0, 0, -1, tr);
        run_instr(OP_BR, 3'b001, 1'b1, 0, 0, -1, tr);
        run_instr(OP_ST, 3'b010, 1'b0, 1, 1, -1, tr);
        run_instr(OP_JAL,3'b000, 1'b0, 0, 0, -1, tr);

        // Push the 4-bit counter past 15 with legal traffic only
        for (int n = 0; n < 12; n++) begin
            pick(1'b0, op, f3);
            run_instr(op, f3, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), -1, tr);
        end

        run_instr(OP_BR, 3'b010, 1'b0, 0, 0, -1, tr);
        chk("br_bad_traps", 32'(tr), 32'd1);
        trap_hold(10);
        do_reset();

        run_instr(OP_BAD, 3'b000, 1'b0, 0, 0, -1, tr);
        chk("illegal_traps", 32'(tr), 32'd1);
        trap_hold(10);
        do_reset();

        run_instr(OP_LD, 3'b000, 1'b0, 0, 3, 1, tr);
        mem_ready = 1'b0;
        cyc("after_rst_fetch", pk(0,0,0,0,0,0,0,0,0,1,0,0,0,3'd0));
        chk("after_rst_retired", 32'(retired), 32'd0);

        // Random traffic, including occasional traps that need a reset
        for (int n = 0; n < 60; n++) begin
            pick(1'b1, op, f3);
            run_instr(op, f3, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), -1, tr);
            if (tr) begin
                trap_hold($urandom_range(1, 4));
                do_reset();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
